// File: rtl/fwht_meas_ctrl_if.sv
// Handshake bundle between the measurement scheduler and the sequency-order generator,
// the pattern loader and the ADC front end.
interface fwht_meas_ctrl_if #(
  parameter int unsigned L_WIDTH = 6
) ();

  logic               seq_reset;  // synchronous reset pulse to the generator
  logic               seq_ce;     // advance pulse to the generator
  logic [L_WIDTH-1:0] seq_index;  // current generator index
  logic               pat_valid;  // pattern request valid
  logic [L_WIDTH-1:0] pat_index;  // pattern index, follows seq_index
  logic               pat_ready;  // pattern loader accepts
  logic               acq_trig;   // one-cycle acquisition trigger
  logic               acq_done;   // acquisition complete pulse

  // Scheduler side
  modport master (
    output seq_reset, seq_ce, pat_valid, pat_index, acq_trig,
    input  seq_index, pat_ready, acq_done
  );

  // Generator / loader / front-end side
  modport slave (
    input  seq_reset, seq_ce, pat_valid, pat_index, acq_trig,
    output seq_index, pat_ready, acq_done
  );

endinterface

// File: rtl/fwht_meas_ctrl.sv
// Measurement scheduler for the single-pixel FWHT acquisition path. Walks the sequency-order
// generator through MEASURES Walsh patterns: issue pattern, settle, trigger, wait for the ADC.
module fwht_meas_ctrl #(
  parameter int unsigned L_WIDTH        = 6,
  parameter int unsigned MEASURES       = 16,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  fwht_meas_ctrl_if.master     bus,
  output logic [L_WIDTH:0]     o_meas_num,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout
);

  localparam int unsigned MeasW   = L_WIDTH + 1;
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Terminal counts are "last value", so a counter of N states spans exactly N cycles.
  localparam logic [MeasW-1:0]   MeasLast   = MeasW'(MEASURES - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TmoW-1:0]    TmoLast    = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSeqRst, StIssue, StSettle, StTrig, StWaitAcq, StAdvance, StDone
  } state_e;

  state_e             state_q;
  logic [SettleW-1:0] settle_cnt_q;
  logic [TmoW-1:0]    tmo_cnt_q;
  logic [MeasW-1:0]   meas_num_q;
  logic               seq_reset_q;
  logic               seq_ce_q;
  logic               pat_valid_q;
  logic               acq_trig_q;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;

  // Scheduler FSM; every output is set from the state being entered so it is registered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      meas_num_q   <= '0;
      seq_reset_q  <= 1'b0;
      seq_ce_q     <= 1'b0;
      pat_valid_q  <= 1'b0;
      acq_trig_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // Single-cycle pulses default low
      seq_reset_q <= 1'b0;
      seq_ce_q    <= 1'b0;
      acq_trig_q  <= 1'b0;
      done_q      <= 1'b0;
      if (i_abort && (state_q != StIdle)) begin
        // Abort beats every other transition; count and timeout flag are kept for inspection
        state_q     <= StIdle;
        pat_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start) begin
              state_q     <= StSeqRst;
              seq_reset_q <= 1'b1;
              busy_q      <= 1'b1;
              meas_num_q  <= '0;
              timeout_q   <= 1'b0;
            end
          end
          StSeqRst: begin
            state_q     <= StIssue;
            pat_valid_q <= 1'b1;
          end
          StIssue: begin
            if (bus.pat_ready) begin
              pat_valid_q <= 1'b0;
              if (SETTLE_CYCLES == 0) begin
                state_q    <= StTrig;
                acq_trig_q <= 1'b1;
              end else begin
                state_q      <= StSettle;
                settle_cnt_q <= '0;
              end
            end
          end
          StSettle: begin
            if (settle_cnt_q == SettleLast) begin
              state_q    <= StTrig;
              acq_trig_q <= 1'b1;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          StTrig: begin
            state_q   <= StWaitAcq;
            tmo_cnt_q <= '0;
          end
          StWaitAcq: begin
            // Completion is tested first so it wins over a coincident timeout
            if (bus.acq_done) begin
              meas_num_q <= meas_num_q + 1'b1;
              if (meas_num_q == MeasLast) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q  <= StAdvance;
                seq_ce_q <= 1'b1;
              end
            end else if (tmo_cnt_q == TmoLast) begin
              state_q   <= StIdle;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
          StAdvance: begin
            state_q     <= StIssue;
            pat_valid_q <= 1'b1;
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q     <= StIdle;
            pat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.seq_reset = seq_reset_q;
  assign bus.seq_ce    = seq_ce_q;
  assign bus.pat_valid = pat_valid_q;
  // Generator is frozen while a request is pending, so the index can pass straight through
  assign bus.pat_index = bus.seq_index;
  assign bus.acq_trig  = acq_trig_q;
  assign o_meas_num    = meas_num_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;

endmodule

// File: doc/fwht_meas_ctrl.md
Name: fwht_meas_ctrl

Overview:
Measurement scheduler for the single-pixel FWHT acquisition path. It sequences the sequency-order index generator through MEASURES Walsh patterns. For each pattern it hands the index to the pattern loader, waits a settle time, triggers the detector acquisition and waits for its completion. It sits between the top-level capture FSM (start/abort/done) and the sequency_order generator, pattern loader and ADC front end.

Parameters:
L_WIDTH, 6, index width; must match the generator (bit-reversal is fixed at 6 bits).
MEASURES, 16, measurements per run; legal range 1..2^L_WIDTH.
SETTLE_CYCLES, 8, cycles between pattern acceptance and trigger; 0 is legal.
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_ACQ before aborting; must be ≥1.

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  start a run; sampled only in IDLE
i_abort  in  1  abandon the current run
o_seq_reset  out  1  synchronous reset pulse to the generator
o_seq_ce  out  1  advance pulse to the generator
i_seq_index  in  L_WIDTH  current generator index
o_pat_valid  out  1  pattern request valid
o_pat_index  out  L_WIDTH  pattern index; equals i_seq_index while o_pat_valid is high
i_pat_ready  in  1  pattern loader accepts
o_acq_trig  out  1  one-cycle acquisition trigger
i_acq_done  in  1  acquisition complete pulse
o_meas_num  out  L_WIDTH+1  completed-measurement count
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle run-complete pulse
o_timeout  out  1  sticky acquisition-timeout flag

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; o_meas_num=0, o_timeout=0.
  - Settle and timeout counters cleared.
- All outputs are registered, except o_pat_index, which is a combinational pass-through of i_seq_index.
- States: IDLE, SEQRST, ISSUE, SETTLE, TRIG, WAIT_ACQ, ADVANCE, DONE.
- IDLE:
  - i_start=1 -> SEQRST.
  - On that transition, clear o_meas_num and o_timeout.
- SEQRST: o_seq_reset=1 for exactly one cycle -> ISSUE. The generator shows index 0 in the next cycle.
- ISSUE:
  - o_pat_valid=1; i_seq_index is stable because the generator is not advanced here.
  - Transfer occurs when o_pat_valid && i_pat_ready.
  - On transfer -> SETTLE, or -> TRIG if SETTLE_CYCLES=0.
  - With no ready, valid and index stay held indefinitely.
- SETTLE: stays for exactly SETTLE_CYCLES cycles -> TRIG.
- TRIG: o_acq_trig=1 for one cycle -> WAIT_ACQ. Timeout counter loaded to 0.
- WAIT_ACQ:
  - i_acq_done=1: o_meas_num+=1. If the new value equals MEASURES -> DONE, else -> ADVANCE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: set o_timeout, -> IDLE, no o_done.
  - If i_acq_done and timeout expiry coincide, done wins.
- ADVANCE: o_seq_ce=1 for one cycle -> ISSUE. The new index is valid in ISSUE.
- DONE: o_done=1 for one cycle -> IDLE. o_meas_num holds MEASURES until the next start.
- Per-measurement cost with ready and done immediate: SETTLE_CYCLES+4 cycles.
- i_abort=1 in any non-IDLE state:
  - -> IDLE next edge; no o_done.
  - o_meas_num and o_timeout hold.
  - Abort takes priority over all other transitions.
- Ignored inputs:
  - i_start outside IDLE.
  - i_acq_done outside WAIT_ACQ.
  - i_pat_ready outside ISSUE.
- o_seq_ce and o_seq_reset are never high in the same cycle. o_seq_ce is issued exactly MEASURES-1 times per completed run.
- Reset mid-run returns to IDLE immediately; a new i_start re-resets the generator.

Test Plan:
- Full run, MEASURES=4, SETTLE_CYCLES=2, i_pat_ready=1, i_acq_done pulsed in the first WAIT_ACQ cycle, start sampled at cycle 0 -> o_seq_reset at cycle 1; o_pat_index 0,32,48,16 at cycles 2,8,14,20; o_acq_trig at 5,11,17,23; o_done at 25; o_meas_num=4; o_busy high cycles 1–25.
- Pattern backpressure: i_pat_ready low 5 cycles in ISSUE -> o_pat_valid held and o_pat_index=32 stable; SETTLE starts the cycle after ready rises.
- Timeout: TIMEOUT_CYCLES=16, i_acq_done never asserted -> o_timeout rises 16 cycles after TRIG, state IDLE, o_done never pulses; next i_start clears o_timeout.
- Coincidence: i_acq_done asserted in the final timeout cycle -> o_timeout stays 0 and the run continues.
- Abort in SETTLE of measurement 2 -> IDLE next cycle, o_busy=0, o_meas_num=2, no o_done; restart yields index 0 first.
- Async reset asserted mid-WAIT_ACQ between clock edges -> all outputs 0 immediately; i_start during busy has no effect; SETTLE_CYCLES=0 gives TRIG the cycle after the ISSUE transfer.
